pagerank_phase_sequencer: RTL

//  Top-level iteration controller for the DMP serial pagerank datapath. Sequences each

---
 rtl/pagerank_phase_sequencer_if.sv | 34 +++
 rtl/pagerank_phase_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pagerank_phase_sequencer_if.sv
// Handshake bundle between the pagerank iteration sequencer and the datapath
// blocks it drives (scatter, local update, serializer, compute).
//   master : the sequencer - samples enable/done/converged, drives start pulses,
//            nextIteration, iteration_number and the status flags.
//   slave  : the datapath/host side - the mirror image of master.
interface pagerank_phase_sequencer_if #(
    parameter int NUM_HW_THREADS = 8
);
    logic                      pagerank_enable;
    logic [NUM_HW_THREADS-1:0] scatter_done;
    logic [NUM_HW_THREADS-1:0] gather_done;
    logic                      stream_done;
    logic                      converged;
    logic                      scatter_start;
    logic                      gather_start;
    logic                      stream_start;
    logic                      nextIteration;
    logic [31:0]               iteration_number;
    logic                      busy;
    logic                      pagerank_complete;
    logic                      timeout_error;

    modport master (
        input  pagerank_enable, scatter_done, gather_done, stream_done, converged,
        output scatter_start, gather_start, stream_start, nextIteration,
               iteration_number, busy, pagerank_complete, timeout_error
    );

    modport slave (
        output pagerank_enable, scatter_done, gather_done, stream_done, converged,
        input  scatter_start, gather_start, stream_start, nextIteration,
               iteration_number, busy, pagerank_complete, timeout_error
    );
endinterface

// File: rtl/pagerank_phase_sequencer.sv
// Iteration controller for the DMP serial pagerank datapath. Walks every
// iteration through SCATTER -> GATHER -> STREAM, collecting per-thread done
// flags in a sticky mask, then either starts the next iteration or finishes
// (converged or iteration cap). A per-phase watchdog forces ERROR if a phase
// overstays PHASE_TIMEOUT cycles.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      pagerank_phase_sequencer_if.master: enable, done flags, converged
//            in; start pulses, nextIteration, iteration_number, busy,
//            pagerank_complete, timeout_error out (all registered)
module pagerank_phase_sequencer #(
    parameter int NUM_HW_THREADS = 8,
    parameter int MAX_ITERATIONS = 100,
    parameter int PHASE_TIMEOUT  = 1024
) (
    input  logic                         clock,
    input  logic                         reset_n,
    pagerank_phase_sequencer_if.master   bus
);
    localparam int              WD_W      = $clog2(PHASE_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(PHASE_TIMEOUT - 1);
    localparam logic [31:0]     ITER_LAST = 32'(MAX_ITERATIONS - 1);

    typedef enum logic [2:0] {IDLE, SCATTER, GATHER, STREAM, DONE, ERROR} state_t;

    state_t                    state;
    logic [NUM_HW_THREADS-1:0] done_mask;   // shared by SCATTER/GATHER, cleared on every exit
    logic [WD_W-1:0]           wd;
    logic                      scatter_start, gather_start, stream_start, next_iter;
    logic [31:0]               iter;
    logic                      busy, complete, terr;

    // Include flags arriving this cycle so the exit is taken on the same edge.
    logic scatter_all, gather_all, wd_expired, last_iter, active;
    assign scatter_all = &(done_mask | bus.scatter_done);
    assign gather_all  = &(done_mask | bus.gather_done);
    assign wd_expired  = (wd == WD_LAST);
    assign last_iter   = (iter == ITER_LAST);
    assign active      = (state == SCATTER) || (state == GATHER) || (state == STREAM);

    always_ff @(posedge clock) begin
        scatter_start <= 1'b0;
        gather_start  <= 1'b0;
        stream_start  <= 1'b0;
        next_iter     <= 1'b0;
        if (!reset_n) begin
            state     <= IDLE;
            done_mask <= '0;
            wd        <= '0;
            iter      <= '0;
            busy      <= 1'b0;
            complete  <= 1'b0;
            terr      <= 1'b0;
        end else if (active && !bus.pagerank_enable) begin
            // Abort: silent return to IDLE; iteration count kept until next start.
            state     <= IDLE;
            done_mask <= '0;
            wd        <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.pagerank_enable) begin
                        state         <= SCATTER;
                        scatter_start <= 1'b1;
                        iter          <= '0;
                        done_mask     <= '0;
                        wd            <= '0;
                        busy          <= 1'b1;
                    end
                end
                SCATTER: begin
                    if (scatter_all) begin
                        state        <= GATHER;
                        gather_start <= 1'b1;
                        done_mask    <= '0;
                        wd           <= '0;
                    end else if (wd_expired) begin
                        state     <= ERROR;
                        busy      <= 1'b0;
                        terr      <= 1'b1;
                        done_mask <= '0;
                        wd        <= '0;
                    end else begin
                        done_mask <= done_mask | bus.scatter_done;
                        wd        <= wd + 1'b1;
                    end
                end
                GATHER: begin
                    if (gather_all) begin
                        state        <= STREAM;
                        stream_start <= 1'b1;
                        done_mask    <= '0;
                        wd           <= '0;
                    end else if (wd_expired) begin
                        state     <= ERROR;
                        busy      <= 1'b0;
                        terr      <= 1'b1;
                        done_mask <= '0;
                        wd        <= '0;
                    end else begin
                        done_mask <= done_mask | bus.gather_done;
                        wd        <= wd + 1'b1;
                    end
                end
                STREAM: begin
                    if (bus.stream_done) begin
                        wd <= '0;
                        if (bus.converged || last_iter) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            complete <= 1'b1;
                        end else begin
                            state         <= SCATTER;
                            scatter_start <= 1'b1;
                            next_iter     <= 1'b1;
                            // Saturating: never wraps past the cap.
                            iter          <= last_iter ? iter : iter + 32'd1;
                        end
                    end else if (wd_expired) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        terr  <= 1'b1;
                        wd    <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.pagerank_enable) begin
                        state    <= IDLE;
                        complete <= 1'b0;
                    end
                end
                ERROR: begin
                    if (!bus.pagerank_enable) begin
                        state <= IDLE;
                        terr  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.scatter_start     = scatter_start;
    assign bus.gather_start      = gather_start;
    assign bus.stream_start      = stream_start;
    assign bus.nextIteration     = next_iter;
    assign bus.iteration_number  = iter;
    assign bus.busy              = busy;
    assign bus.pagerank_complete = complete;
    assign bus.timeout_error     = terr;
endmodule
